// File: rtl/tetris_cmd_pkg.sv
// Shared encodings and default timing for the
// falling-block command scheduler.
package tetris_cmd_pkg;

  typedef enum logic [2:0] {
    CMD_NONE   = 3'd0,
    CMD_LEFT   = 3'd1,
    CMD_RIGHT  = 3'd2,
    CMD_ROTATE = 3'd3,
    CMD_DOWN   = 3'd4
  } cmd_e;

  typedef enum logic {
    RUN  = 1'b0,
    FAIL = 1'b1
  } state_e;

  localparam int unsigned DEF_GRAV_PERIOD = 50000000;
  localparam int unsigned DEF_GRAV_STEP   = 3000000;
  localparam int unsigned DEF_GRAV_MIN    = 5000000;
  localparam int unsigned DEF_SOFT_PERIOD = 5000000;
  localparam int unsigned DEF_DAS_DELAY   = 20000000;
  localparam int unsigned DEF_DAS_REPEAT  = 5000000;
  localparam int unsigned DEF_CNT_W       = 32;

endpackage

// File: rtl/tetris_cmd_scheduler_key_autorepeat.sv
// Edge detect plus delayed auto-repeat for one
// held direction key.
module key_autorepeat
  import tetris_cmd_pkg::*;
#(
  parameter int unsigned CNT_W      = DEF_CNT_W,
  parameter int unsigned DAS_DELAY  = DEF_DAS_DELAY,
  parameter int unsigned DAS_REPEAT = DEF_DAS_REPEAT
) (
  input  logic clk,
  input  logic rst,
  input  logic key,
  input  logic inhibit,
  input  logic freeze,
  output logic evt
);

  typedef logic [CNT_W-1:0] cnt_t;

  logic prev_q;
  logic prev_d;
  cnt_t cnt_q;
  cnt_t cnt_d;

  // First press fires at once; a held key re-fires
  // after the delay and then at the repeat pace.
  always_comb begin
    prev_d = prev_q;
    cnt_d  = cnt_q;
    evt    = 1'b0;
    if (!freeze) begin
      prev_d = key;
      if (inhibit || !key) begin
        cnt_d = '0;
      end else if (!prev_q) begin
        evt   = 1'b1;
        cnt_d = cnt_t'(1);
      end else if (cnt_q >= cnt_t'(DAS_DELAY)) begin
        evt   = 1'b1;
        cnt_d = cnt_t'(DAS_DELAY - DAS_REPEAT + 1);
      end else begin
        cnt_d = cnt_q + cnt_t'(1);
      end
    end
  end

  // Key history and hold timer
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      prev_q <= prev_d;
      cnt_q  <= cnt_d;
    end
  end

endmodule

// File: rtl/tetris_cmd_scheduler.sv
// Merges key levels and gravity into one stream
// of prioritised single-cycle move commands.
module tetris_cmd_scheduler
  import tetris_cmd_pkg::*;
#(
  parameter int unsigned GRAV_PERIOD = DEF_GRAV_PERIOD,
  parameter int unsigned GRAV_STEP   = DEF_GRAV_STEP,
  parameter int unsigned GRAV_MIN    = DEF_GRAV_MIN,
  parameter int unsigned SOFT_PERIOD = DEF_SOFT_PERIOD,
  parameter int unsigned DAS_DELAY   = DEF_DAS_DELAY,
  parameter int unsigned DAS_REPEAT  = DEF_DAS_REPEAT,
  parameter int unsigned CNT_W       = DEF_CNT_W
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       key_left,
  input  logic       key_right,
  input  logic       key_up,
  input  logic       key_down,
  input  logic [6:0] score,
  input  logic       fail,
  output logic [2:0] cmd,
  output logic       cmd_valid,
  input  logic       cmd_ready,
  output logic [3:0] level
);

  localparam int unsigned XW = CNT_W + 5;

  typedef logic [CNT_W-1:0] cnt_t;
  typedef logic [XW-1:0]    wide_t;

  state_e     state_q;
  state_e     state_d;
  logic [3:0] level_q;
  logic [3:0] level_d;
  cnt_t       grav_q;
  cnt_t       grav_d;

  logic left_q;
  logic left_d;
  logic right_q;
  logic right_d;
  logic up_q;
  logic up_d;
  logic up_prev_q;
  logic up_prev_d;

  logic pend_down_q;
  logic pend_down_d;
  logic pend_rot_q;
  logic pend_rot_d;
  logic pend_left_q;
  logic pend_left_d;
  logic pend_right_q;
  logic pend_right_d;

  cmd_e cmd_q;
  cmd_e cmd_d;
  logic cmd_valid_q;
  logic cmd_valid_d;

  logic  freeze;
  logic  inhibit;
  logic  load;
  logic  ev_left;
  logic  ev_right;
  logic  ev_rot;
  logic  ev_down;
  logic  take_down;
  logic  take_rot;
  logic  take_left;
  logic  take_right;
  wide_t dec;
  cnt_t  eff_period;
  logic  score_unused;

  assign score_unused = ^score[2:0];

  assign freeze  = (state_q == FAIL) || fail;
  assign inhibit = left_q && right_q;
  assign load    = !cmd_valid_q || cmd_ready;
  assign ev_rot  = up_q && !up_prev_q && !freeze;

  assign cmd       = cmd_q;
  assign cmd_valid = cmd_valid_q;
  assign level     = level_q;

  key_autorepeat #(
    .CNT_W      (CNT_W),
    .DAS_DELAY  (DAS_DELAY),
    .DAS_REPEAT (DAS_REPEAT)
  ) u_rep_left (
    .clk     (clk),
    .rst     (rst),
    .key     (left_q),
    .inhibit (inhibit),
    .freeze  (freeze),
    .evt     (ev_left)
  );

  key_autorepeat #(
    .CNT_W      (CNT_W),
    .DAS_DELAY  (DAS_DELAY),
    .DAS_REPEAT (DAS_REPEAT)
  ) u_rep_right (
    .clk     (clk),
    .rst     (rst),
    .key     (right_q),
    .inhibit (inhibit),
    .freeze  (freeze),
    .evt     (ev_right)
  );

  // Gravity period: soft drop, else level-scaled
  // with a floor; the wide product cannot wrap.
  always_comb begin
    dec = wide_t'(level_q) * wide_t'(GRAV_STEP);
    if (key_down) begin
      eff_period = cnt_t'(SOFT_PERIOD);
    end else if (dec + wide_t'(GRAV_MIN)
                 >= wide_t'(GRAV_PERIOD)) begin
      eff_period = cnt_t'(GRAV_MIN);
    end else begin
      eff_period = cnt_t'(wide_t'(GRAV_PERIOD) - dec);
    end
  end

  // Gravity tick; >= lets a shrunken period fire
  // on the very next cycle.
  always_comb begin
    ev_down = !freeze
           && (grav_q >= eff_period - cnt_t'(1));
    grav_d  = grav_q;
    if (!freeze) begin
      grav_d = ev_down ? '0 : grav_q + cnt_t'(1);
    end
  end

  // Slot refill with fixed priority, flag merging
  // and game-over freeze.
  always_comb begin
    cmd_d       = cmd_q;
    cmd_valid_d = cmd_valid_q;
    take_down   = 1'b0;
    take_rot    = 1'b0;
    take_left   = 1'b0;
    take_right  = 1'b0;
    if (freeze) begin
      cmd_d       = CMD_NONE;
      cmd_valid_d = 1'b0;
    end else if (load) begin
      cmd_valid_d = 1'b1;
      if (pend_down_q) begin
        cmd_d     = CMD_DOWN;
        take_down = 1'b1;
      end else if (pend_rot_q) begin
        cmd_d    = CMD_ROTATE;
        take_rot = 1'b1;
      end else if (pend_left_q) begin
        cmd_d     = CMD_LEFT;
        take_left = 1'b1;
      end else if (pend_right_q) begin
        cmd_d      = CMD_RIGHT;
        take_right = 1'b1;
      end else begin
        cmd_d       = CMD_NONE;
        cmd_valid_d = 1'b0;
      end
    end
  end

  // Pending flags, key samples, level and state
  always_comb begin
    left_d    = key_left;
    right_d   = key_right;
    up_d      = key_up;
    up_prev_d = up_q;
    level_d   = score[6:3];
    state_d   = state_q;
    if (state_q == RUN && fail) begin
      state_d = FAIL;
    end
    if (freeze) begin
      up_prev_d    = up_prev_q;
      pend_down_d  = 1'b0;
      pend_rot_d   = 1'b0;
      pend_left_d  = 1'b0;
      pend_right_d = 1'b0;
    end else begin
      pend_down_d  = (pend_down_q && !take_down)
                  || ev_down;
      pend_rot_d   = (pend_rot_q && !take_rot)
                  || ev_rot;
      pend_left_d  = (pend_left_q && !take_left)
                  || ev_left;
      pend_right_d = (pend_right_q && !take_right)
                  || ev_right;
    end
  end

  // All scheduler state, registered together
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= RUN;
      level_q      <= '0;
      grav_q       <= '0;
      left_q       <= 1'b0;
      right_q      <= 1'b0;
      up_q         <= 1'b0;
      up_prev_q    <= 1'b0;
      pend_down_q  <= 1'b0;
      pend_rot_q   <= 1'b0;
      pend_left_q  <= 1'b0;
      pend_right_q <= 1'b0;
      cmd_q        <= CMD_NONE;
      cmd_valid_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      level_q      <= level_d;
      grav_q       <= grav_d;
      left_q       <= left_d;
      right_q      <= right_d;
      up_q         <= up_d;
      up_prev_q    <= up_prev_d;
      pend_down_q  <= pend_down_d;
      pend_rot_q   <= pend_rot_d;
      pend_left_q  <= pend_left_d;
      pend_right_q <= pend_right_d;
      cmd_q        <= cmd_d;
      cmd_valid_q  <= cmd_valid_d;
    end
  end

endmodule

// File: tb/tb_tetris_cmd_scheduler.sv
// Directed bench for the command scheduler with
// small timing parameters.
module tb_tetris_cmd_scheduler;

  localparam logic [2:0] C_NONE  = 3'd0;
  localparam logic [2:0] C_LEFT  = 3'd1;
  localparam logic [2:0] C_RIGHT = 3'd2;
  localparam logic [2:0] C_ROT   = 3'd3;
  localparam logic [2:0] C_DOWN  = 3'd4;

  logic       clk = 1'b0;
  logic       rst;
  logic       key_left;
  logic       key_right;
  logic       key_up;
  logic       key_down;
  logic [6:0] score;
  logic       fail;
  logic       cmd_ready;
  logic [2:0] cmd;
  logic       cmd_valid;
  logic [3:0] level;

  int checks = 0;
  int passes = 0;
  int ec     = 0;
  int n_left;
  int n_right;
  int n_down;
  int n_any;

  tetris_cmd_scheduler #(
    .GRAV_PERIOD (16),
    .GRAV_STEP   (2),
    .GRAV_MIN    (4),
    .SOFT_PERIOD (3),
    .DAS_DELAY   (8),
    .DAS_REPEAT  (3),
    .CNT_W       (32)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .key_left  (key_left),
    .key_right (key_right),
    .key_up    (key_up),
    .key_down  (key_down),
    .score     (score),
    .fail      (fail),
    .cmd       (cmd),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .level     (level)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
    ec++;
  endtask

  task automatic run_to(input int n);
    while (ec < n) step();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    ec  = 0;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    assert (got === exp) passes++;
    else $error("FAIL %s: got %0d expected %0d",
                tag, got, exp);
  endtask

  initial begin
    rst       = 1'b1;
    key_left  = 1'b0;
    key_right = 1'b0;
    key_up    = 1'b0;
    key_down  = 1'b0;
    score     = '0;
    fail      = 1'b0;
    cmd_ready = 1'b1;

    // reset values
    step();
    step();
    chk("rst_valid", 32'(cmd_valid), 0);
    chk("rst_cmd", 32'(cmd), 32'(C_NONE));
    chk("rst_level", 32'(level), 0);
    rst = 1'b0;
    ec  = 0;

    // gravity at level 0: first DOWN at edge 17
    n_any = 0;
    repeat (16) begin
      step();
      if (cmd_valid) n_any++;
    end
    chk("grav_quiet_1_16", n_any, 0);
    step();
    chk("grav_valid_17", 32'(cmd_valid), 1);
    chk("grav_cmd_17", 32'(cmd), 32'(C_DOWN));
    step();
    chk("grav_single_18", 32'(cmd_valid), 0);
    run_to(32);
    chk("grav_idle_32", 32'(cmd_valid), 0);
    run_to(33);
    chk("grav_33", 32'({cmd_valid, cmd}),
        32'({1'b1, C_DOWN}));

    // left held 20 cycles: events 0,8,11,14,17
    key_left = 1'b1;
    n_left = 0;
    n_down = 0;
    for (int i = 1; i <= 26; i++) begin
      step();
      if (i == 3)
        chk("left_first_lat", 32'({cmd_valid, cmd}),
            32'({1'b1, C_LEFT}));
      if (cmd_valid && cmd == C_LEFT) n_left++;
      if (cmd_valid && cmd == C_DOWN) n_down++;
      if (i == 20) key_left = 1'b0;
    end
    chk("left_das_count", n_left, 5);
    chk("left_win_down", n_down, 1);

    // both directions held: fully inhibited
    key_left  = 1'b1;
    key_right = 1'b1;
    n_left  = 0;
    n_right = 0;
    for (int i = 1; i <= 25; i++) begin
      step();
      if (cmd_valid && cmd == C_LEFT) n_left++;
      if (cmd_valid && cmd == C_RIGHT) n_right++;
      if (i == 20) begin
        key_left  = 1'b0;
        key_right = 1'b0;
      end
    end
    chk("both_keys_lr", n_left + n_right, 0);

    // backpressure, hold and merging
    do_reset();
    cmd_ready = 1'b0;
    run_to(17);
    chk("bp_down_17", 32'({cmd_valid, cmd}),
        32'({1'b1, C_DOWN}));
    run_to(20);
    key_up = 1'b1;
    run_to(21);
    key_up = 1'b0;
    run_to(30);
    chk("bp_hold_30", 32'({cmd_valid, cmd}),
        32'({1'b1, C_DOWN}));
    run_to(50);
    chk("bp_hold_50", 32'({cmd_valid, cmd}),
        32'({1'b1, C_DOWN}));
    cmd_ready = 1'b1;
    run_to(51);
    chk("bp_down2_51", 32'({cmd_valid, cmd}),
        32'({1'b1, C_DOWN}));
    run_to(52);
    chk("bp_rot_52", 32'({cmd_valid, cmd}),
        32'({1'b1, C_ROT}));
    run_to(53);
    chk("bp_empty_53", 32'(cmd_valid), 0);
    n_any = 0;
    while (ec < 60) begin
      step();
      if (cmd_valid) n_any++;
    end
    chk("bp_no_extra", n_any, 0);

    // level scaling, floor and soft drop
    score = 7'd40;
    do_reset();
    chk("lvl_after_rst", 32'(level), 0);
    run_to(1);
    chk("lvl5", 32'(level), 5);
    run_to(6);
    chk("l5_idle_6", 32'(cmd_valid), 0);
    run_to(7);
    chk("l5_down_7", 32'({cmd_valid, cmd}),
        32'({1'b1, C_DOWN}));
    run_to(12);
    chk("l5_idle_12", 32'(cmd_valid), 0);
    run_to(13);
    chk("l5_down_13", 32'({cmd_valid, cmd}),
        32'({1'b1, C_DOWN}));
    score = 7'd127;
    run_to(14);
    chk("lvl15", 32'(level), 15);
    run_to(16);
    chk("l15_idle_16", 32'(cmd_valid), 0);
    run_to(17);
    chk("l15_down_17", 32'({cmd_valid, cmd}),
        32'({1'b1, C_DOWN}));
    run_to(20);
    chk("l15_idle_20", 32'(cmd_valid), 0);
    run_to(21);
    chk("l15_down_21", 32'({cmd_valid, cmd}),
        32'({1'b1, C_DOWN}));
    score = 7'd0;
    run_to(30);
    key_down = 1'b1;
    run_to(31);
    chk("soft_idle_31", 32'(cmd_valid), 0);
    run_to(32);
    chk("soft_fire_32", 32'({cmd_valid, cmd}),
        32'({1'b1, C_DOWN}));
    run_to(34);
    chk("soft_idle_34", 32'(cmd_valid), 0);
    run_to(35);
    chk("soft_down_35", 32'({cmd_valid, cmd}),
        32'({1'b1, C_DOWN}));
    run_to(38);
    chk("soft_down_38", 32'({cmd_valid, cmd}),
        32'({1'b1, C_DOWN}));
    key_down = 1'b0;

    // game over withdraws and freezes
    do_reset();
    cmd_ready = 1'b0;
    run_to(17);
    key_left = 1'b1;
    run_to(18);
    key_left = 1'b0;
    run_to(20);
    chk("fail_pre_20", 32'({cmd_valid, cmd}),
        32'({1'b1, C_DOWN}));
    fail = 1'b1;
    run_to(21);
    chk("fail_valid_21", 32'(cmd_valid), 0);
    chk("fail_cmd_21", 32'(cmd), 32'(C_NONE));
    fail      = 1'b0;
    cmd_ready = 1'b1;
    key_up    = 1'b1;
    key_left  = 1'b1;
    n_any = 0;
    for (int i = 1; i <= 100; i++) begin
      step();
      if (cmd_valid) n_any++;
      if (i == 50) begin
        key_up   = 1'b0;
        key_left = 1'b0;
      end
    end
    chk("fail_frozen", n_any, 0);
    do_reset();
    n_any = 0;
    repeat (16) begin
      step();
      if (cmd_valid) n_any++;
    end
    chk("fail_rst_quiet", n_any, 0);
    step();
    chk("fail_rst_down17", 32'({cmd_valid, cmd}),
        32'({1'b1, C_DOWN}));

    // async reset mid-handshake
    do_reset();
    cmd_ready = 1'b0;
    run_to(17);
    key_up = 1'b1;
    run_to(18);
    key_up = 1'b0;
    run_to(20);
    chk("arst_pre", 32'({cmd_valid, cmd}),
        32'({1'b1, C_DOWN}));
    #2;
    rst = 1'b1;
    #1;
    chk("arst_valid_async", 32'(cmd_valid), 0);
    chk("arst_cmd_async", 32'(cmd), 32'(C_NONE));
    do_reset();
    cmd_ready = 1'b1;
    n_any = 0;
    repeat (16) begin
      step();
      if (cmd_valid) n_any++;
    end
    chk("arst_flags_empty", n_any, 0);
    step();
    chk("arst_down17", 32'({cmd_valid, cmd}),
        32'({1'b1, C_DOWN}));

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
